md_ctrl: RTL and testbench
==========================

# md_ctrl

Multicycle MIPS control unit: a Moore FSM driving every control input of the multicycle datapath (IR/PC/register-file write enables, mux selects, ALU operation, extend mode) plus memory read/write strobes. It sits directly upstream of the datapath. It consumes the datapath's `Inst`, `zero` and `overflow` outputs and the memory-interface `MIO_ready`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; state ← IF
- `MIO_ready`  in  1  memory ready; 0 freezes FSM
- `Inst`  in  32  IR contents; uses opcode [31:26], funct [5:0]
- `zero`  in  1  ALU zero (combinational, current cycle)
- `overflow`  in  1  ALU signed overflow (combinational)
- `IorD`  out  1  0 = PC, 1 = ALUOut as memory address
- `IRWrite`  out  1  IR load enable
- `RegDst`  out  2  0 = rt, 1 = rd, 2 = $31
- `RegWrite`  out  1  register-file write enable
- `MemtoReg`  out  2  0 = ALUOut, 1 = MDR, 2 = {imm,16'b0}, 3 = PC
- `ALUSrcA`  out  2  0 = PC, 1 = rs, 2 = shamt
- `ALUSrcB`  out  2  0 = rt, 1 = 4, 2 = ext imm, 3 = ext imm<<2
- `PCSource`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- `PCWrite`, `PCWriteCond`, `Branch`  out  1 each  PC update controls
- `ALU_operation`  out  4  AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SRL 0101, SUB 0110, SLT 0111, SLL 1000
- `sign`  out  1  1 = sign-extend, 0 = zero-extend
- `MemRead`, `MemWrite`  out  1 each  memory strobes
- `state`  out  4  current state code (debug)

## Operation
- Outputs are pure decode of `state` (+ `zero` for `Branch`).
- Defaults: every output is 0, except `ALU_operation` = ADD.
- State codes and transitions:
  - **IF (0)**: `MemRead`, `IRWrite`, `ALUSrcB`=1, ADD, `PCWrite`. Next: ID.
  - **ID (1)**: `ALUSrcA`=0, `ALUSrcB`=3, ADD, `sign`=1 (branch target → ALUOut). Next state is chosen by opcode.
    - lw/sw (100011/101011) → MEM_ADR
    - R-type (000000): jr (funct 001000) → JR; otherwise → R_EXE
    - beq/bne (000100/000101) → BRANCH
    - j (000010) → JUMP
    - jal (000011) → JAL
    - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110 → I_EXE
    - lui (001111) → LUI
    - any other opcode → IF (executes as NOP)
  - **MEM_ADR (2)**: `ALUSrcA`=1, `ALUSrcB`=2, ADD, `sign`=1. Next: MEM_RD (lw) or MEM_WR (sw).
  - **MEM_RD (3)**: `IorD`, `MemRead`. Next: LW_WB.
  - **LW_WB (4)**: `RegDst`=0, `MemtoReg`=1, `RegWrite`. Next: IF.
  - **MEM_WR (5)**: `IorD`, `MemWrite`. Next: IF.
  - **R_EXE (6)**: `ALUSrcA`=2 for sll/srl, else 1; `ALUSrcB`=0; op from funct:
    - add 100000 → ADD; sub 100010 → SUB; and 100100 → AND; or 100101 → OR
    - xor 100110 → XOR; nor 100111 → NOR; slt 101010 → SLT; sll 000000 → SLL; srl 000010 → SRL
    - Next: R_WB.
  - **R_WB (7)**: `RegDst`=1, `MemtoReg`=0, `RegWrite` (suppressed if `ov_q`). Next: IF.
  - **BRANCH (8)**: `ALUSrcA`=1, `ALUSrcB`=0, SUB, `PCWriteCond`, `PCSource`=1; `Branch` = `zero` (beq) or ~`zero` (bne). Next: IF.
  - **JUMP (9)**: `PCSource`=2, `PCWrite`. Next: IF.
  - **I_EXE (10)**: `ALUSrcA`=1, `ALUSrcB`=2.
    - addi → ADD, `sign`=1; slti → SLT, `sign`=1
    - andi/ori/xori → AND/OR/XOR, `sign`=0
    - Next: I_WB.
  - **I_WB (11)**: `RegDst`=0, `MemtoReg`=0, `RegWrite` (suppressed if `ov_q`). Next: IF.
  - **LUI (12)**: `RegDst`=0, `MemtoReg`=2, `RegWrite`. Next: IF.
  - **JR (13)**: `ALUSrcA`=1, `ALUSrcB`=0 (rt=$0), OR, `PCSource`=0, `PCWrite`. Next: IF.
  - **JAL (14)**: `RegDst`=2, `MemtoReg`=3, `RegWrite`, `PCSource`=2, `PCWrite`. $31 receives PC+4, since PC was already incremented in IF.
  - Code 15 is unreachable; if entered, next state is IF with all outputs at default.
- Overflow flag `ov_q`:
  - Loaded at end of R_EXE (add/sub) or I_EXE (addi) with `overflow`.
  - Cleared in all other states.
  - Set `ov_q` suppresses `RegWrite` in the following WB state only.

## Timing
- Cycles per instruction (with `MIO_ready`=1 throughout):
  - 5: lw
  - 4: sw, R-type, I-type
  - 3: lui, beq/bne, j, jal, jr
- Stall: with `MIO_ready`=0, state holds and selects/ALU op stay stable. `IRWrite`, `RegWrite`, `PCWrite`, `PCWriteCond` and `MemWrite` are forced 0. They re-assert on the first cycle `MIO_ready`=1.
- Reset:
  - While `reset`=1, all write enables and strobes are 0.
  - After release, `state`=0 (IF) and the first fetch occurs in that cycle.
  - Reset mid-instruction aborts it: no further register or memory write.
- `Branch` follows `zero` combinationally within BRANCH; all other outputs change only on the clock edge.

## Test plan
- Reset held for 2 cycles then released → `state`=0; `MemRead`=1, `IRWrite`=1, `PCWrite`=1, `ALUSrcB`=1, `ALU_operation`=0010.
- `Inst`=0x8C430004 (lw) with `MIO_ready`=1 → states 0,1,2,3,4,0; `RegWrite`=1 only in state 4, with `MemtoReg`=1.
- `Inst`=0x00852020 (add) with `overflow`=1 in R_EXE → R_WB has `RegWrite`=0. Repeat with `overflow`=0 → `RegWrite`=1, `RegDst`=1.
- `Inst`=0x14A00003 (bne): `zero`=1 → `Branch`=0; `zero`=0 → `Branch`=1; `PCWriteCond`=1, `PCSource`=1.
- `Inst`=0x0C000010 (jal) → state 14 with `RegDst`=2, `MemtoReg`=3, `PCSource`=2, `PCWrite`=1.
- `MIO_ready`=0 for 3 cycles in MEM_WR (sw) → state stays 5 and `MemWrite`=0 during the stall. On the ready cycle `MemWrite`=1, and the next state is IF.

Source files
------------

// File: rtl/md_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that decodes the current state
// into every datapath control, plus memory strobes and an overflow guard.
module md_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic [31:0] Inst,
  input  logic        zero,
  input  logic        overflow,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [3:0]  ALU_operation,
  output logic        sign,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MADR   = 4'd2,
    S_MRD    = 4'd3,
    S_LWWB   = 4'd4,
    S_MWR    = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXE   = 4'd10,
    S_IWB    = 4'd11,
    S_LUI    = 4'd12,
    S_JR     = 4'd13,
    S_JAL    = 4'd14,
    S_BAD    = 4'd15
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;

  state_t     state_q, state_d;
  logic       ov_q, ov_d;
  logic [5:0] op, fn;
  logic       unused_bits;

  assign op          = Inst[31:26];
  assign fn          = Inst[5:0];
  assign unused_bits = ^Inst[25:6];
  assign state       = state_q;

  always_comb begin
    state_d = S_IF;
    unique case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (op)
          6'b100011,
          6'b101011: state_d = S_MADR;
          6'b000000: state_d = (fn == 6'b001000) ? S_JR : S_REXE;
          6'b000100,
          6'b000101: state_d = S_BRANCH;
          6'b000010: state_d = S_JUMP;
          6'b000011: state_d = S_JAL;
          6'b001000, 6'b001010, 6'b001100,
          6'b001101, 6'b001110: state_d = S_IEXE;
          6'b001111: state_d = S_LUI;
          default:   state_d = S_IF;
        endcase
      end
      S_MADR:  state_d = (op == 6'b100011) ? S_MRD : S_MWR;
      S_MRD:   state_d = S_LWWB;
      S_REXE:  state_d = S_RWB;
      S_IEXE:  state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  // Only signed adds/subtracts can overflow; the flag lives one cycle
  always_comb begin
    ov_d = 1'b0;
    if (state_q == S_REXE &&
        (fn == 6'b100000 || fn == 6'b100010))
      ov_d = overflow;
    if (state_q == S_IEXE && op == 6'b001000)
      ov_d = overflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      ov_q    <= 1'b0;
    end else if (MIO_ready) begin
      state_q <= state_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 2'd0;
    RegWrite      = 1'b0;
    MemtoReg      = 2'd0;
    ALUSrcA       = 2'd0;
    ALUSrcB       = 2'd0;
    PCSource      = 2'd0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    ALU_operation = OP_ADD;
    sign          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    unique case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        PCWrite = 1'b1;
      end
      S_ID: begin
        ALUSrcB = 2'd3;
        sign    = 1'b1;
      end
      S_MADR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        sign    = 1'b1;
      end
      S_MRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_LWWB: begin
        MemtoReg = 2'd1;
        RegWrite = 1'b1;
      end
      S_MWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_REXE: begin
        ALUSrcA = (fn == 6'b000000 || fn == 6'b000010)
                  ? 2'd2 : 2'd1;
        case (fn)
          6'b100010: ALU_operation = OP_SUB;
          6'b100100: ALU_operation = OP_AND;
          6'b100101: ALU_operation = OP_OR;
          6'b100110: ALU_operation = OP_XOR;
          6'b100111: ALU_operation = OP_NOR;
          6'b101010: ALU_operation = OP_SLT;
          6'b000000: ALU_operation = OP_SLL;
          6'b000010: ALU_operation = OP_SRL;
          default:   ALU_operation = OP_ADD;
        endcase
      end
      S_RWB: begin
        RegDst   = 2'd1;
        RegWrite = ~ov_q;
      end
      S_BRANCH: begin
        ALUSrcA       = 2'd1;
        ALU_operation = OP_SUB;
        PCWriteCond   = 1'b1;
        PCSource      = 2'd1;
        Branch        = (op == 6'b000101) ? ~zero : zero;
      end
      S_JUMP: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
      end
      S_IEXE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        case (op)
          6'b001010: begin
            ALU_operation = OP_SLT;
            sign          = 1'b1;
          end
          6'b001100: ALU_operation = OP_AND;
          6'b001101: ALU_operation = OP_OR;
          6'b001110: ALU_operation = OP_XOR;
          default:   sign = 1'b1;
        endcase
      end
      S_IWB:  RegWrite = ~ov_q;
      S_LUI: begin
        MemtoReg = 2'd2;
        RegWrite = 1'b1;
      end
      S_JR: begin
        ALUSrcA       = 2'd1;
        ALU_operation = OP_OR;
        PCWrite       = 1'b1;
      end
      S_JAL: begin
        RegDst   = 2'd2;
        MemtoReg = 2'd3;
        RegWrite = 1'b1;
        PCSource = 2'd2;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
    // Stalls and reset must never let a write slip through
    if (reset || !MIO_ready) begin
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemWrite    = 1'b0;
    end
    if (reset) begin
      MemRead = 1'b0;
      Branch  = 1'b0;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: expectations are queued per cycle
// and popped against the observed control outputs.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset, MIO_ready, zero, overflow;
  logic [31:0] Inst;
  logic        IorD, IRWrite, RegWrite, PCWrite, PCWriteCond;
  logic        Branch, sign, MemRead, MemWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0]  ALU_operation, state;

  md_ctrl dut (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready),
    .Inst(Inst), .zero(zero), .overflow(overflow),
    .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch),
    .ALU_operation(ALU_operation), .sign(sign),
    .MemRead(MemRead), .MemWrite(MemWrite), .state(state)
  );

  always #5 clk = ~clk;

  typedef enum int {
    F_ST, F_RW, F_MT, F_RD, F_MW, F_MR, F_IRW, F_PCW,
    F_PCC, F_PCS, F_BR, F_ALU, F_SA, F_SB, F_SGN, F_IORD
  } fld_t;

  typedef struct {
    string      tag;
    fld_t       fld;
    logic [3:0] val;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [3:0] obs(fld_t f);
    case (f)
      F_ST:    return state;
      F_RW:    return {3'b0, RegWrite};
      F_MT:    return {2'b0, MemtoReg};
      F_RD:    return {2'b0, RegDst};
      F_MW:    return {3'b0, MemWrite};
      F_MR:    return {3'b0, MemRead};
      F_IRW:   return {3'b0, IRWrite};
      F_PCW:   return {3'b0, PCWrite};
      F_PCC:   return {3'b0, PCWriteCond};
      F_PCS:   return {2'b0, PCSource};
      F_BR:    return {3'b0, Branch};
      F_ALU:   return ALU_operation;
      F_SA:    return {2'b0, ALUSrcA};
      F_SB:    return {2'b0, ALUSrcB};
      F_SGN:   return {3'b0, sign};
      default: return {3'b0, IorD};
    endcase
  endfunction

  task automatic check(string tag, logic [3:0] got,
                       logic [3:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(string tag, fld_t f, logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, obs(e.fld), e.val);
    end
  endtask

  // Check queued expectations, then advance one clock.
  task automatic cyc();
    drain();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch_decode(string t);
    push({t, "_if"}, F_ST, 4'd0);
    cyc();
    push({t, "_id"}, F_ST, 4'd1);
    cyc();
  endtask

  initial begin
    reset = 1'b1; MIO_ready = 1'b1; zero = 1'b0;
    overflow = 1'b0; Inst = 32'h0;
    @(posedge clk); @(negedge clk);
    push("rst_mr", F_MR, 4'd0);
    push("rst_irw", F_IRW, 4'd0);
    push("rst_pcw", F_PCW, 4'd0);
    push("rst_st", F_ST, 4'd0);
    cyc();
    reset = 1'b0;
    push("if_st", F_ST, 4'd0);
    push("if_mr", F_MR, 4'd1);
    push("if_irw", F_IRW, 4'd1);
    push("if_pcw", F_PCW, 4'd1);
    push("if_sb", F_SB, 4'd1);
    push("if_alu", F_ALU, 4'd2);
    drain();

    // lw: 0,1,2,3,4 then back to IF
    Inst = 32'h8C430004;
    fetch_decode("lw");
    push("lw_adr", F_ST, 4'd2);
    push("lw_adr_sgn", F_SGN, 4'd1);
    push("lw_adr_rw", F_RW, 4'd0);
    cyc();
    push("lw_rd", F_ST, 4'd3);
    push("lw_rd_iord", F_IORD, 4'd1);
    push("lw_rd_rw", F_RW, 4'd0);
    cyc();
    push("lw_wb", F_ST, 4'd4);
    push("lw_wb_rw", F_RW, 4'd1);
    push("lw_wb_mt", F_MT, 4'd1);
    cyc();

    // add with and without overflow
    for (int k = 0; k < 2; k++) begin
      Inst = 32'h00852020;
      fetch_decode("add");
      overflow = (k == 0);
      push("add_exe", F_ST, 4'd6);
      push("add_alu", F_ALU, 4'd2);
      push("add_sa", F_SA, 4'd1);
      cyc();
      overflow = 1'b0;
      push("add_wb", F_ST, 4'd7);
      push("add_wb_rw", F_RW, (k == 0) ? 4'd0 : 4'd1);
      push("add_wb_rd", F_RD, 4'd1);
      cyc();
    end

    // sll uses shamt operand
    Inst = 32'h00041080;
    fetch_decode("sll");
    push("sll_exe", F_ST, 4'd6);
    push("sll_alu", F_ALU, 4'd8);
    push("sll_sa", F_SA, 4'd2);
    cyc();
    push("sll_wb", F_ST, 4'd7);
    cyc();

    // bne: Branch follows ~zero combinationally
    Inst = 32'h14A00003;
    fetch_decode("bne");
    zero = 1'b1;
    push("bne_st", F_ST, 4'd8);
    push("bne_br_z1", F_BR, 4'd0);
    push("bne_pcc", F_PCC, 4'd1);
    push("bne_pcs", F_PCS, 4'd1);
    push("bne_alu", F_ALU, 4'd6);
    drain();
    zero = 1'b0;
    push("bne_br_z0", F_BR, 4'd1);
    cyc();

    // jal
    Inst = 32'h0C000010;
    fetch_decode("jal");
    push("jal_st", F_ST, 4'd14);
    push("jal_rd", F_RD, 4'd2);
    push("jal_mt", F_MT, 4'd3);
    push("jal_pcs", F_PCS, 4'd2);
    push("jal_pcw", F_PCW, 4'd1);
    push("jal_rw", F_RW, 4'd1);
    cyc();

    // addi overflow suppresses I_WB write
    Inst = 32'h20420001;
    fetch_decode("addi");
    overflow = 1'b1;
    push("addi_st", F_ST, 4'd10);
    push("addi_sgn", F_SGN, 4'd1);
    push("addi_sb", F_SB, 4'd2);
    cyc();
    overflow = 1'b0;
    push("addi_wb", F_ST, 4'd11);
    push("addi_wb_rw", F_RW, 4'd0);
    cyc();

    // andi zero-extends
    Inst = 32'h3042FFFF;
    fetch_decode("andi");
    push("andi_st", F_ST, 4'd10);
    push("andi_sgn", F_SGN, 4'd0);
    push("andi_alu", F_ALU, 4'd0);
    cyc();
    push("andi_wb_rw", F_RW, 4'd1);
    cyc();

    // lui
    Inst = 32'h3C011234;
    fetch_decode("lui");
    push("lui_st", F_ST, 4'd12);
    push("lui_mt", F_MT, 4'd2);
    push("lui_rw", F_RW, 4'd1);
    cyc();

    // unknown opcode acts as NOP
    Inst = 32'hFC000000;
    fetch_decode("nop");

    // sw with 3-cycle stall in MEM_WR
    Inst = 32'hAC430004;
    fetch_decode("sw");
    push("sw_adr", F_ST, 4'd2);
    cyc();
    MIO_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push("sw_stall_st", F_ST, 4'd5);
      push("sw_stall_mw", F_MW, 4'd0);
      cyc();
    end
    MIO_ready = 1'b1;
    push("sw_rdy_st", F_ST, 4'd5);
    push("sw_rdy_mw", F_MW, 4'd1);
    cyc();
    push("sw_next", F_ST, 4'd0);

    // stall in IF gates write enables
    MIO_ready = 1'b0;
    push("ifst_irw", F_IRW, 4'd0);
    push("ifst_pcw", F_PCW, 4'd0);
    push("ifst_mr", F_MR, 4'd1);
    cyc();
    MIO_ready = 1'b1;
    push("ifst_hold", F_ST, 4'd0);
    cyc();

    // reset mid-instruction aborts the writeback
    Inst = 32'h8C430004;
    push("ab_st", F_ST, 4'd1);
    cyc();
    reset = 1'b1;
    push("ab_rw", F_RW, 4'd0);
    push("ab_mr", F_MR, 4'd0);
    cyc();
    reset = 1'b0;
    push("ab_if", F_ST, 4'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
